in_service_control: RTL
=======================

# in_service_control

Interrupt-acknowledge and in-service sequencer for the 8259 PIC, 8086 mode. It consumes the one-hot `interrupt` output of the priority resolver and runs the two-pulse INTA handshake with the CPU. It owns the in-service register, the IRR clear strobes, the vector bus drive, EOI handling and the `priority_rotate` value fed back to the resolver.

## Interface
Parameters:
- `VECTOR_BASE_W`, 5: width of the vector base (T7..T3).

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `interrupt`  in  8  one-hot resolved request from the priority resolver; 0 means none pending.
- `inta_n`  in  1  CPU acknowledge, active low, already synchronized to `clk`.
- `vector_base`  in  5  ICW2 T7..T3.
- `auto_eoi`  in  1  ICW4 AEOI.
- `rotate_on_aeoi`  in  1  OCW2 rotate-in-AEOI mode.
- `eoi_valid`  in  1  one-cycle OCW2 EOI strobe.
- `eoi_specific`  in  1  1 = specific EOI using `eoi_level`.
- `eoi_rotate`  in  1  1 = rotate priority on this EOI.
- `eoi_level`  in  3  level for a specific EOI.
- `int_out`  out  1  INT to CPU.
- `in_service_register`  out  8  ISR.
- `clear_irr`  out  8  one-cycle pulse that clears the acknowledged IRR bit.
- `priority_rotate`  out  3  level with current highest priority.
- `data_out`  out  8  vector byte.
- `data_oe`  out  1  drive enable for `data_out`.

## Operation
- Reset values: all outputs 0; state `IDLE`.
- Edge detect on `inta_n` uses a registered previous value, reset to 1.
  - Fall: prev=1, now=0.
  - Rise: prev=0, now=1.
- States:
  - `IDLE`: `interrupt != 0` → set `int_out`, go `WAIT_ACK1`.
  - `WAIT_ACK1`: on fall, latch `ack_level`.
    - If `interrupt != 0`: `ack_level` = encoded `interrupt`. Set ISR bit, pulse `clear_irr` with that bit.
    - If `interrupt == 0` (request withdrawn): spurious. `ack_level` = 7, ISR not set, no `clear_irr` pulse.
    - Clear `int_out`; go `ACK1`.
  - `ACK1`: on rise, go `WAIT_ACK2`.
  - `WAIT_ACK2`: on fall, go `ACK2`.
  - `ACK2`: `data_out = {vector_base, ack_level}`, `data_oe = 1`.
    - On rise: `data_oe` = 0, `data_out` = 0.
    - If `auto_eoi` and not spurious: clear ISR[`ack_level`]. If `rotate_on_aeoi`, also set `priority_rotate = ack_level + 1` (mod 8).
    - Go `IDLE`.
- Non-specific EOI:
  - Clears the highest-priority set ISR bit, scanning levels `priority_rotate`, `priority_rotate+1`, … (mod 8).
  - With `eoi_rotate`, sets `priority_rotate` = cleared level + 1 (mod 8).
  - ISR empty → no effect.
- Specific EOI: clears ISR[`eoi_level`]. With `eoi_rotate`, sets `priority_rotate = eoi_level + 1` (mod 8). Clearing an already-clear bit is legal; rotation still applies.
- Simultaneous EOI and ISR set in the same cycle:
  - The EOI target is computed from the pre-update ISR.
  - The set is applied after the clear, so set wins if both hit the same bit.
- Simultaneous AEOI rotate and EOI rotate: the EOI value wins.
- EOI is accepted in any state.
- A fall in `IDLE` is ignored.
- `interrupt` changes after the first fall do not affect `ack_level`.
- Reset mid-handshake: immediate return to reset values. The CPU-side sequence is abandoned.

## Timing
- `int_out` rises 1 cycle after `interrupt` becomes nonzero in `IDLE`.
- ISR bit, `clear_irr` pulse and `int_out` clear appear 1 cycle after the first fall is detected. Detection happens in the cycle `inta_n` is first sampled low.
- `clear_irr` is high for exactly 1 cycle.
- `data_oe` and `data_out` are valid from 1 cycle after the second fall until 1 cycle after the second rise.
- EOI effects (ISR, `priority_rotate`) are visible 1 cycle after `eoi_valid`.
- Minimum INTA low/high width: 1 cycle.

## Structure
- Package `pic_pkg`:
  - state enum (`IDLE`, `WAIT_ACK1`, `ACK1`, `WAIT_ACK2`, `ACK2`);
  - `level_t` (3 bits);
  - `SPURIOUS_LEVEL` = 7.
- Sub-module `isr_priority_encoder`: combinational. Inputs: ISR and `priority_rotate`. Outputs: highest-priority in-service level and a valid flag. Used by non-specific EOI.
- One-hot to level encoding is done inline.

## Test plan
- Basic ack: `interrupt=8'h08`, `vector_base=5'h10`, two INTA pulses.
  - Expect `int_out` high, then cleared at the first ack.
  - Expect `clear_irr=8'h08` for 1 cycle, ISR=`8'h08`, `data_out=8'h83` during the second pulse.
- AEOI with rotate: level 5 acked, `auto_eoi=1`, `rotate_on_aeoi=1` → after the second rise, ISR=0 and `priority_rotate=6`.
- Non-specific EOI: ISR=`8'h84`, `priority_rotate=3` → EOI clears bit 7 (ISR=`8'h04`). A second EOI with rotate clears bit 2 and sets `priority_rotate=3`.
- Spurious: `interrupt` drops to 0 before the first fall → `data_out={vector_base,3'd7}`, ISR unchanged, no `clear_irr` pulse.
- Collision: specific EOI on level 2 in the same cycle as ISR set of level 2 → ISR bit 2 ends set.
- Reset asserted during `ACK2` → all outputs 0 immediately. A fresh request then acks normally.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types for the 8259 in-service / INTA sequencing logic.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACK1,
    ACK1,
    WAIT_ACK2,
    ACK2
  } state_t;

  typedef logic [2:0] level_t;

  localparam level_t SPURIOUS_LEVEL = 3'd7;

  // Level that becomes highest priority once `l` has been serviced.
  function automatic level_t level_after(input level_t l);
    return l + 3'd1;
  endfunction

endpackage

// File: rtl/isr_priority_encoder.sv
// Finds the highest-priority in-service level, scanning upward from
// priority_rotate with wrap-around. Used to target a non-specific EOI.
module isr_priority_encoder
  import pic_pkg::*;
(
  input  logic [7:0] isr,
  input  level_t     priority_rotate,
  output level_t     level,
  output logic       valid
);

  logic [7:0] rotated;
  level_t     offset;

  // rotated[i] is the ISR bit for the level i steps below the current top.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      assign rotated[gi] = isr[priority_rotate + level_t'(gi)];
    end
  endgenerate

  always_comb begin
    offset = '0;
    for (int i = 7; i >= 0; i--) begin
      if (rotated[i]) offset = level_t'(i);
    end
  end

  assign valid = |isr;
  assign level = priority_rotate + offset;

endmodule

// File: rtl/in_service_control.sv
// 8259 (8086 mode) INTA handshake sequencer: owns the ISR, IRR clear strobes,
// vector drive, EOI handling and the rotating-priority pointer.
module in_service_control
  import pic_pkg::*;
#(
  parameter int VECTOR_BASE_W = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               interrupt,
  input  logic                     inta_n,
  input  logic [VECTOR_BASE_W-1:0] vector_base,
  input  logic                     auto_eoi,
  input  logic                     rotate_on_aeoi,
  input  logic                     eoi_valid,
  input  logic                     eoi_specific,
  input  logic                     eoi_rotate,
  input  logic [2:0]               eoi_level,
  output logic                     int_out,
  output logic [7:0]               in_service_register,
  output logic [7:0]               clear_irr,
  output logic [2:0]               priority_rotate,
  output logic [VECTOR_BASE_W+2:0] data_out,
  output logic                     data_oe
);

  state_t     state_reg;
  logic       inta_prev_reg;
  level_t     ack_level_reg;
  logic       spurious_reg;

  logic       inta_fall;
  logic       inta_rise;
  level_t     irq_level;
  level_t     nsp_level;
  logic       nsp_valid;
  logic       eoi_hit;
  level_t     eoi_target;
  logic       ack_set;
  logic       aeoi_clear;
  logic [7:0] set_mask;
  logic [7:0] clear_mask;
  logic [7:0] isr_next;
  level_t     rotate_next;

  assign inta_fall = inta_prev_reg & ~inta_n;
  assign inta_rise = ~inta_prev_reg & inta_n;

  always_comb begin
    irq_level = '0;
    for (int i = 7; i >= 0; i--) begin
      if (interrupt[i]) irq_level = level_t'(i);
    end
  end

  isr_priority_encoder u_isr_priority_encoder (
    .isr             (in_service_register),
    .priority_rotate (priority_rotate),
    .level           (nsp_level),
    .valid           (nsp_valid)
  );

  // EOI target comes from the ISR as it stood before this cycle's update.
  always_comb begin
    eoi_hit    = 1'b0;
    eoi_target = eoi_level;
    if (eoi_valid) begin
      if (eoi_specific) begin
        eoi_hit = 1'b1;
      end else if (nsp_valid) begin
        eoi_hit    = 1'b1;
        eoi_target = nsp_level;
      end
    end
  end

  assign ack_set    = (state_reg == WAIT_ACK1) && inta_fall && (|interrupt);
  assign aeoi_clear = (state_reg == ACK2) && inta_rise && auto_eoi && !spurious_reg;
  assign set_mask   = ack_set ? (8'd1 << irq_level) : 8'd0;

  always_comb begin
    clear_mask  = '0;
    rotate_next = priority_rotate;
    if (aeoi_clear) begin
      clear_mask[ack_level_reg] = 1'b1;
      if (rotate_on_aeoi) rotate_next = level_after(ack_level_reg);
    end
    if (eoi_hit) begin
      clear_mask[eoi_target] = 1'b1;
      if (eoi_rotate) rotate_next = level_after(eoi_target);
    end
    // Set is applied after the clear so a same-cycle acknowledge wins.
    isr_next = (in_service_register & ~clear_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg           <= IDLE;
      inta_prev_reg       <= 1'b1;
      ack_level_reg       <= '0;
      spurious_reg        <= 1'b0;
      int_out             <= 1'b0;
      in_service_register <= '0;
      clear_irr           <= '0;
      priority_rotate     <= '0;
      data_out            <= '0;
      data_oe             <= 1'b0;
    end else begin
      inta_prev_reg       <= inta_n;
      clear_irr           <= '0;
      in_service_register <= isr_next;
      priority_rotate     <= rotate_next;
      case (state_reg)
        IDLE: begin
          if (|interrupt) begin
            int_out   <= 1'b1;
            state_reg <= WAIT_ACK1;
          end
        end
        WAIT_ACK1: begin
          if (inta_fall) begin
            int_out   <= 1'b0;
            state_reg <= ACK1;
            if (|interrupt) begin
              ack_level_reg <= irq_level;
              spurious_reg  <= 1'b0;
              clear_irr     <= set_mask;
            end else begin
              ack_level_reg <= SPURIOUS_LEVEL;
              spurious_reg  <= 1'b1;
            end
          end
        end
        ACK1: begin
          if (inta_rise) state_reg <= WAIT_ACK2;
        end
        WAIT_ACK2: begin
          if (inta_fall) begin
            data_oe   <= 1'b1;
            data_out  <= {vector_base, ack_level_reg};
            state_reg <= ACK2;
          end
        end
        ACK2: begin
          if (inta_rise) begin
            data_oe   <= 1'b0;
            data_out  <= '0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
